bp_sacc_spm_dma_ctrl: RTL and testbench

// - Sequences word-granular DMA from memory into one of the accelerator's scratchpads (sample / e1 / m_e0).
// - Issues 4B uc_rd commands with bounded outstanding requests, writes in-order responses into the selected SPM,

---
 rtl/bp_sacc_spm_dma_ctrl.sv | 157 +++++++++++++++
 tb/tb_bp_sacc_spm_dma_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_sacc_spm_dma_ctrl.sv
// Word-granular DMA sequencer: streams 4B uncached reads from memory into a selected scratchpad,
// bounding in-flight commands and reporting sticky done/err status to the CSR block.
module bp_sacc_spm_dma_ctrl #(
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned spm_els_p         = 4096,
    parameter int unsigned num_spm_p         = 3,
    parameter int unsigned len_width_p       = 16,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic                         clear_i,
    input  logic [paddr_width_p-1:0]     src_addr_i,
    input  logic [len_width_p-1:0]       length_i,
    input  logic [1:0]                   spm_sel_i,
    input  logic [$clog2(spm_els_p)-1:0] spm_base_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         mem_cmd_v_o,
    output logic [paddr_width_p-1:0]     mem_cmd_addr_o,
    input  logic                         mem_cmd_yumi_i,
    input  logic                         mem_resp_v_i,
    input  logic [31:0]                  mem_resp_data_i,
    output logic                         mem_resp_ready_o,
    input  logic                         spm_ready_i,
    output logic [num_spm_p-1:0]         spm_w_v_o,
    output logic [$clog2(spm_els_p)-1:0] spm_addr_o,
    output logic [31:0]                  spm_data_o
);

    localparam int unsigned spm_idx_w = $clog2(spm_els_p);
    localparam int unsigned out_w     = $clog2(max_outstanding_p + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                   state_q, state_d;
    logic [paddr_width_p-1:0] src_q, src_d;
    logic [len_width_p-1:0]   len_q, len_d;
    logic [1:0]               sel_q, sel_d;
    logic [spm_idx_w-1:0]     base_q, base_d;
    logic [len_width_p-1:0]   issued_q, issued_d;
    logic [len_width_p-1:0]   received_q, received_d;
    logic [out_w-1:0]         out_q, out_d;
    logic                     err_q, err_d;

    logic                     active;
    logic                     cmd_v;
    logic                     cmd_fire;
    logic                     resp_ready;
    logic                     resp_fire;
    logic                     sel_ok;
    logic                     set_err;
    logic [len_width_p-1:0]   issued_nxt;
    logic [len_width_p-1:0]   received_nxt;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            src_q      <= '0;
            len_q      <= '0;
            sel_q      <= '0;
            base_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            len_q      <= len_d;
            sel_q      <= sel_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            out_q      <= out_d;
            err_q      <= err_d;
        end
    end

    // Next-state, counters and handshake decode
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        len_d        = len_q;
        sel_d        = sel_q;
        base_d       = base_q;
        issued_d     = issued_q;
        received_d   = received_q;
        out_d        = out_q;
        err_d        = err_q;
        set_err      = 1'b0;

        active       = (state_q == ISSUE) || (state_q == DRAIN);
        cmd_v        = (state_q == ISSUE) && (32'(out_q) < max_outstanding_p) && (issued_q < len_q);
        cmd_fire     = cmd_v && mem_cmd_yumi_i;
        resp_ready   = active ? spm_ready_i : 1'b1;
        resp_fire    = mem_resp_v_i && resp_ready;
        sel_ok       = 32'(spm_sel_i) < num_spm_p;
        issued_nxt   = issued_q + len_width_p'(cmd_fire);
        received_nxt = received_q + len_width_p'(resp_fire);

        case (state_q)
            IDLE, DONE: begin
                if (clear_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
                if (start_i) begin
                    if (sel_ok) begin
                        src_d      = src_addr_i & ~paddr_width_p'(3);
                        len_d      = length_i;
                        sel_d      = spm_sel_i;
                        base_d     = spm_base_i;
                        issued_d   = '0;
                        received_d = '0;
                        out_d      = '0;
                        state_d    = (length_i == '0) ? DONE : ISSUE;
                    end else begin
                        set_err = 1'b1;
                    end
                end
                // Responses with nothing outstanding are drained and flagged
                if (resp_fire) set_err = 1'b1;
            end
            ISSUE, DRAIN: begin
                issued_d   = issued_nxt;
                received_d = received_nxt;
                out_d      = out_q + out_w'(cmd_fire) - out_w'(resp_fire);
                if (start_i) set_err = 1'b1;
                if (state_q == ISSUE) begin
                    if (issued_nxt == len_q) begin
                        state_d = (received_nxt == len_q) ? DONE : DRAIN;
                    end
                end else if (received_nxt == len_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (set_err) err_d = 1'b1;
    end

    assign busy_o           = active;
    assign done_o           = (state_q == DONE);
    assign err_o            = err_q;
    assign mem_cmd_v_o      = cmd_v;
    assign mem_cmd_addr_o   = src_q + paddr_width_p'({issued_q, 2'b00});
    assign mem_resp_ready_o = resp_ready;
    assign spm_w_v_o        = (active && resp_fire) ? (num_spm_p'(1) << sel_q) : '0;
    assign spm_addr_o       = base_q + spm_idx_w'(received_q);
    assign spm_data_o       = mem_resp_data_i;

endmodule

// File: tb/tb_bp_sacc_spm_dma_ctrl.sv
// Scoreboard bench for bp_sacc_spm_dma_ctrl: a small memory model answers commands in order,
// expected commands and SPM writes are queued by the stimulus and popped by a monitor.
module tb_bp_sacc_spm_dma_ctrl;

    localparam int unsigned PW = 40;
    localparam int unsigned SW = 12;
    localparam int unsigned NS = 3;
    localparam int unsigned LW = 16;

    typedef struct packed {
        logic [NS-1:0] we;
        logic [SW-1:0] addr;
        logic [31:0]   data;
    } spm_wr_t;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i, clear_i;
    logic [PW-1:0] src_addr_i;
    logic [LW-1:0] length_i;
    logic [1:0]    spm_sel_i;
    logic [SW-1:0] spm_base_i;
    logic          busy_o, done_o, err_o;
    logic          mem_cmd_v_o;
    logic [PW-1:0] mem_cmd_addr_o;
    logic          mem_cmd_yumi_i;
    logic          mem_resp_v_i;
    logic [31:0]   mem_resp_data_i;
    logic          mem_resp_ready_o;
    logic          spm_ready_i;
    logic [NS-1:0] spm_w_v_o;
    logic [SW-1:0] spm_addr_o;
    logic [31:0]   spm_data_o;

    logic [PW-1:0] exp_cmd[$];
    spm_wr_t       exp_spm[$];
    logic [31:0]   pend[$];
    int            checks = 0;
    int            passed = 0;
    int            cmd_cnt = 0;
    bit            yumi_en = 1'b1;
    bit            resp_en = 1'b1;

    always #5 clk_i = ~clk_i;

    bp_sacc_spm_dma_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .clear_i(clear_i),
        .src_addr_i(src_addr_i), .length_i(length_i), .spm_sel_i(spm_sel_i), .spm_base_i(spm_base_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i), .mem_resp_ready_o(mem_resp_ready_o),
        .spm_ready_i(spm_ready_i), .spm_w_v_o(spm_w_v_o), .spm_addr_o(spm_addr_o), .spm_data_o(spm_data_o)
    );

    function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Memory model: accept commands when enabled, return queued words in order
    always @(posedge clk_i) begin
        #1;
        mem_cmd_yumi_i  = yumi_en && mem_cmd_v_o;
        mem_resp_v_i    = resp_en && (pend.size() > 0);
        mem_resp_data_i = (pend.size() > 0) ? pend[0] : 32'h0;
    end

    // Monitor: compare every command and SPM write against the scoreboard
    always @(negedge clk_i) begin
        spm_wr_t e;
        if (reset_i) begin
            if (mem_resp_v_i && mem_resp_ready_o && pend.size() > 0) void'(pend.pop_front());
            if (mem_cmd_v_o && mem_cmd_yumi_i) begin
                cmd_cnt++;
                if (exp_cmd.size() == 0) check("cmd_unexpected", mem_cmd_addr_o, 64'h0);
                else check("cmd_addr", mem_cmd_addr_o, exp_cmd.pop_front());
                pend.push_back(mem_word(mem_cmd_addr_o));
            end
            if (spm_w_v_o != '0) begin
                if (exp_spm.size() == 0) begin
                    check("spm_unexpected_write", spm_w_v_o, 64'h0);
                end else begin
                    e = exp_spm.pop_front();
                    check("spm_we", spm_w_v_o, e.we);
                    check("spm_addr", spm_addr_o, e.addr);
                    check("spm_data", spm_data_o, e.data);
                end
            end
        end
    end

    task automatic start_xfer(input logic [PW-1:0] src, input logic [LW-1:0] len,
                              input logic [1:0] sel, input logic [SW-1:0] base);
        @(posedge clk_i); #1;
        src_addr_i = src; length_i = len; spm_sel_i = sel; spm_base_i = base;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic clear_pulse();
        @(posedge clk_i); #1;
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic expect_xfer(input logic [PW-1:0] src, input int len,
                               input logic [1:0] sel, input logic [SW-1:0] base);
        for (int i = 0; i < len; i++) begin
            exp_cmd.push_back(src + PW'(4 * i));
            exp_spm.push_back('{we: NS'(1) << sel, addr: base + SW'(i), data: mem_word(src + PW'(4 * i))});
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check(name, done_o, 1);
    endtask

    task automatic scoreboard_empty(input string name);
        check({name, "_cmds_left"}, exp_cmd.size(), 0);
        check({name, "_writes_left"}, exp_spm.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] wrap_addr[4];
        reset_i = 1'b0; start_i = 1'b0; clear_i = 1'b0;
        src_addr_i = '0; length_i = '0; spm_sel_i = '0; spm_base_i = '0;
        mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_data_i = '0;
        spm_ready_i = 1'b1;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cmd_v", mem_cmd_v_o, 0);
        check("rst_spm_w_v", spm_w_v_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;

        // Basic 8-word transfer into SPM0
        expect_xfer(40'h30_0000, 8, 2'd0, 12'd0);
        start_xfer(40'h30_0000, 16'd8, 2'd0, 12'd0);
        wait_done("t1_done", 100);
        check("t1_busy", busy_o, 0);
        scoreboard_empty("t1");
        clear_pulse();
        check("t1_clr_done", done_o, 0);

        // Outstanding limit with responses held off
        resp_en = 1'b0;
        cmd_cnt = 0;
        expect_xfer(40'h1000, 6, 2'd2, 12'd100);
        start_xfer(40'h1000, 16'd6, 2'd2, 12'd100);
        repeat (12) @(negedge clk_i);
        check("t2_in_flight", cmd_cnt, 4);
        check("t2_cmd_v_blocked", mem_cmd_v_o, 0);
        check("t2_busy", busy_o, 1);
        resp_en = 1'b1;
        wait_done("t2_done", 100);
        scoreboard_empty("t2");
        clear_pulse();

        // SPM index wrap on SPM1, plus start while busy
        wrap_addr = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        for (int i = 0; i < 4; i++) begin
            exp_cmd.push_back(40'h2000 + PW'(4 * i));
            exp_spm.push_back('{we: 3'b010, addr: wrap_addr[i], data: mem_word(40'h2000 + PW'(4 * i))});
        end
        start_xfer(40'h2000, 16'd4, 2'd1, 12'd4094);
        @(posedge clk_i); #1;
        src_addr_i = 40'h9999_0000; length_i = 16'd1; spm_sel_i = 2'd0; spm_base_i = 12'd7;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("t3_err_busy_start", err_o, 1);
        check("t3_still_busy", busy_o, 1);
        wait_done("t3_done", 100);
        scoreboard_empty("t3");
        check("t3_err_sticky", err_o, 1);
        clear_pulse();
        check("t3_clr_err", err_o, 0);
        check("t3_clr_done", done_o, 0);

        // Zero-length transfer
        cmd_cnt = 0;
        start_xfer(40'h7000, 16'd0, 2'd0, 12'd0);
        @(negedge clk_i);
        check("t4_done", done_o, 1);
        check("t4_busy", busy_o, 0);
        check("t4_no_cmds", cmd_cnt, 0);
        clear_pulse();

        // SPM back-pressure during DRAIN
        resp_en = 1'b0;
        cmd_cnt = 0;
        expect_xfer(40'h4000, 4, 2'd0, 12'd10);
        start_xfer(40'h4000, 16'd4, 2'd0, 12'd10);
        for (int n = 0; n < 20 && cmd_cnt < 4; n++) @(negedge clk_i);
        check("t5_cmds", cmd_cnt, 4);
        @(posedge clk_i); #1;
        spm_ready_i = 1'b0;
        resp_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i);
            check("t5_resp_ready_low", mem_resp_ready_o, 0);
        end
        check("t5_busy", busy_o, 1);
        @(posedge clk_i); #1;
        spm_ready_i = 1'b1;
        wait_done("t5_done", 100);
        scoreboard_empty("t5");
        clear_pulse();
        check("t5_clr_done", done_o, 0);
        check("t5_clr_err", err_o, 0);
        check("t5_clr_busy", busy_o, 0);

        // Invalid scratchpad select
        start_xfer(40'h100, 16'd4, 2'd3, 12'd0);
        @(negedge clk_i);
        check("t6_err", err_o, 1);
        check("t6_busy", busy_o, 0);
        check("t6_cmd_v", mem_cmd_v_o, 0);
        clear_pulse();
        check("t6_clr_err", err_o, 0);

        // Reset mid-ISSUE, then stale responses arrive in IDLE
        resp_en = 1'b0;
        expect_xfer(40'h5000, 8, 2'd1, 12'd0);
        start_xfer(40'h5000, 16'd8, 2'd1, 12'd0);
        repeat (3) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        check("t7_rst_busy", busy_o, 0);
        check("t7_rst_cmd_v", mem_cmd_v_o, 0);
        check("t7_rst_spm_w_v", spm_w_v_o, 0);
        check("t7_rst_err", err_o, 0);
        exp_cmd.delete();
        exp_spm.delete();
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        check("t7_stale_pending", pend.size() > 0, 1);
        resp_en = 1'b1;
        for (int n = 0; n < 20 && pend.size() > 0; n++) @(negedge clk_i);
        @(negedge clk_i);
        check("t7_stale_drained", pend.size(), 0);
        check("t7_err", err_o, 1);
        check("t7_busy", busy_o, 0);
        clear_pulse();
        check("t7_clr_err", err_o, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
